requant_out: RTL and testbench

REQUANT_OUT -- requirements
Module: requant_out

---
 rtl/requant_out.sv | 163 ++++++++++++++++
 tb/tb_requant_out.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/requant_out.sv
// rtl/requant_out.sv - per-channel int8 requantizer: scale, round, shift, saturate (optional ReLU via REQUANT_OUT_RELU_EN)
module requant_out (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [34:0] in_data,
   input  logic [1:0]  in_ch,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_data,
   output logic [1:0]  out_ch,
   input  logic        cfg_we,
   input  logic [1:0]  cfg_ch,
   input  logic [15:0] cfg_scale,
   input  logic [4:0]  cfg_shift,
   output logic [15:0] sat_cnt,
   input  logic        sat_clr
);

   // per-channel configuration
   logic [15:0]        r_scale [0:3];
   logic [4:0]         r_shift [0:3];

   // stage 1: input word plus its looked-up configuration
   logic               r1_valid;
   logic [34:0]        r1_data;
   logic [1:0]         r1_ch;
   logic [15:0]        r1_scale;
   logic [4:0]         r1_shift;

   // stage 2: full product
   logic               r2_valid;
   logic signed [50:0] r2_prod;
   logic [1:0]         r2_ch;
   logic [4:0]         r2_shift;

   // stage 3: output register
   logic               r3_valid;
   logic [7:0]         r3_data;
   logic [1:0]         r3_ch;
   logic               r3_sat;
   logic [15:0]        r_sat_cnt;

   logic               w_adv;
   logic signed [51:0] w_prod_full;
   logic signed [51:0] w_prod_ext;
   logic signed [51:0] w_round_inc;
   logic signed [51:0] w_rounded;
   logic signed [51:0] w_shifted;
   logic signed [51:0] w_act;
   logic               w_hi;
   logic               w_lo;
   logic [7:0]         w_q;
   logic               w_out_xfer;

   // whole pipeline advances together whenever the output slot is free
   assign w_adv      = !r3_valid || out_ready;
   assign in_ready   = w_adv;
   assign w_out_xfer = r3_valid && out_ready;

   // config writes land at the edge; a same-cycle lookup sees the old entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            r_scale[i] <= 16'd1;
            r_shift[i] <= 5'd0;
         end
      end else if (cfg_we) begin
         r_scale[cfg_ch] <= cfg_scale;
         r_shift[cfg_ch] <= cfg_shift;
      end
   end

   // stage 1: capture the word and its channel's scale/shift
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r1_valid <= 1'b0;
         r1_data  <= '0;
         r1_ch    <= '0;
         r1_scale <= '0;
         r1_shift <= '0;
      end else if (w_adv) begin
         r1_valid <= in_valid;
         if (in_valid) begin
            r1_data  <= in_data;
            r1_ch    <= in_ch;
            r1_scale <= r_scale[in_ch];
            r1_shift <= r_shift[in_ch];
         end
      end
   end

   // scale is unsigned, so it is widened with a zero sign bit before the signed multiply
   assign w_prod_full = $signed(r1_data) * $signed({1'b0, r1_scale});

   // stage 2: register the 51-bit product
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r2_valid <= 1'b0;
         r2_prod  <= '0;
         r2_ch    <= '0;
         r2_shift <= '0;
      end else if (w_adv) begin
         r2_valid <= r1_valid;
         if (r1_valid) begin
            r2_prod  <= w_prod_full[50:0];
            r2_ch    <= r1_ch;
            r2_shift <= r1_shift;
         end
      end
   end

   // round half up, then arithmetic shift; one guard bit keeps the add from overflowing
   assign w_prod_ext  = {r2_prod[50], r2_prod};
   assign w_round_inc = (r2_shift == 5'd0) ? 52'sd0 : $signed(52'd1 << (r2_shift - 5'd1));
   assign w_rounded   = w_prod_ext + w_round_inc;
   assign w_shifted   = w_rounded >>> r2_shift;

`ifdef REQUANT_OUT_RELU_EN
   assign w_act = w_shifted[51] ? 52'sd0 : w_shifted;
`else
   assign w_act = w_shifted;
`endif

   assign w_hi = w_act > 52'sd127;
   assign w_lo = w_act < -52'sd128;
   assign w_q  = w_hi ? 8'h7F : (w_lo ? 8'h80 : w_act[7:0]);

   // stage 3: clamped int8 result held until downstream takes it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r3_valid <= 1'b0;
         r3_data  <= '0;
         r3_ch    <= '0;
         r3_sat   <= 1'b0;
      end else if (w_adv) begin
         r3_valid <= r2_valid;
         if (r2_valid) begin
            r3_data <= w_q;
            r3_ch   <= r2_ch;
            r3_sat  <= w_hi || w_lo;
         end
      end
   end

   // saturation counter: clear wins, increments stick at all-ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sat_cnt <= '0;
      end else if (sat_clr) begin
         r_sat_cnt <= '0;
      end else if (w_out_xfer && r3_sat && (r_sat_cnt != 16'hFFFF)) begin
         r_sat_cnt <= r_sat_cnt + 16'd1;
      end
   end

   assign out_valid = r3_valid;
   assign out_data  = r3_data;
   assign out_ch    = r3_ch;
   assign sat_cnt   = r_sat_cnt;

endmodule

// File: tb/tb_requant_out.sv
// tb/tb_requant_out.sv - randomized and directed bench for requant_out against an arithmetic reference model
`timescale 1ns/1ps
module tb_requant_out;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [34:0] in_data;
   logic [1:0]  in_ch;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic [1:0]  out_ch;
   logic        cfg_we;
   logic [1:0]  cfg_ch;
   logic [15:0] cfg_scale;
   logic [4:0]  cfg_shift;
   logic [15:0] sat_cnt;
   logic        sat_clr;

   always #5 clk = ~clk;

   requant_out dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_ch     (in_ch),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .cfg_we    (cfg_we),
      .cfg_ch    (cfg_ch),
      .cfg_scale (cfg_scale),
      .cfg_shift (cfg_shift),
      .sat_cnt   (sat_cnt),
      .sat_clr   (sat_clr)
   );

   int n_checks = 0;
   int n_errors = 0;

   // reference state: configuration table, expected-output queue, counter
   longint m_scale [4];
   int     m_shift [4];
   longint q_data [$];
   int     q_ch [$];
   bit     q_sat [$];
   int     m_sat;
   bit     hold;
   logic [7:0] h_data;
   logic [1:0] h_ch;
   bit     acc;
   int     n_out;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint sx8(input logic [7:0] v);
      return longint'($signed(v));
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 4; i++) begin
         m_scale[i] = 1;
         m_shift[i] = 0;
      end
      q_data.delete();
      q_ch.delete();
      q_sat.delete();
      m_sat = 0;
      hold  = 0;
   endfunction

   // quantize one word with plain integer arithmetic
   function automatic void ref_q(input longint d, input int ch, output longint q, output bit s);
      longint p;
      p = d * m_scale[ch];
      if (m_shift[ch] > 0) p = p + (longint'(1) <<< (m_shift[ch] - 1));
      p = p >>> m_shift[ch];
`ifdef REQUANT_OUT_RELU_EN
      if (p < 0) p = 0;
`endif
      s = (p > 127) || (p < -128);
      q = (p > 127) ? 127 : ((p < -128) ? -128 : p);
   endfunction

   // one clock: sample just before the rising edge, update the model, advance
   task automatic step();
      longint q;
      bit     s;
      #4;
      check("sat_cnt", sat_cnt, m_sat);
      if (hold) begin
         check("stall_valid", out_valid, 1);
         check("stall_data", out_data, h_data);
         check("stall_ch", out_ch, h_ch);
      end
      hold   = out_valid && !out_ready;
      h_data = out_data;
      h_ch   = out_ch;
      acc    = in_valid && in_ready;
      if (out_valid && out_ready) begin
         n_out++;
         if (q_data.size() == 0) begin
            check("spurious_out", 1, 0);
         end else begin
            check("out_data", sx8(out_data), q_data.pop_front());
            check("out_ch", out_ch, q_ch.pop_front());
            s = q_sat.pop_front();
            if (s && m_sat != 65535) m_sat++;
         end
      end
      if (sat_clr) m_sat = 0;
      if (acc) begin
         ref_q(longint'($signed(in_data)), int'(in_ch), q, s);
         q_data.push_back(q);
         q_ch.push_back(int'(in_ch));
         q_sat.push_back(s);
      end
      if (cfg_we) begin
         m_scale[cfg_ch] = longint'(cfg_scale);
         m_shift[cfg_ch] = int'(cfg_shift);
      end
      @(posedge clk);
      @(negedge clk);
      if (acc) in_valid = 1'b0;
      cfg_we  = 1'b0;
      sat_clr = 1'b0;
   endtask

   task automatic push_word(input longint d, input int ch);
      int tries;
      in_valid = 1'b1;
      in_data  = d[34:0];
      in_ch    = ch[1:0];
      tries    = 0;
      acc      = 0;
      while (!acc && tries < 50) begin
         step();
         tries++;
      end
      if (!acc) check("push_timeout", 0, 1);
   endtask

   task automatic drain(input int n);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (n) step();
   endtask

   // single word through an empty pipe: latency and value against a fixed constant
   task automatic send_one(input longint d, input int ch, input longint exp, input string tag);
      int lat;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = d[34:0];
      in_ch     = ch[1:0];
      step();
      check({tag, "_acc"}, acc, 1);
      lat = 1;
      while (!out_valid && lat < 20) begin
         step();
         lat++;
      end
      check({tag, "_lat"}, lat, 3);
      check(tag, sx8(out_data), exp);
      step();
   endtask

   function automatic logic [34:0] rand_data();
      logic [63:0] t;
      int          sel;
      sel = $urandom_range(0, 2);
      t   = {$urandom, $urandom};
      if (sel == 0) return t[34:0];
      if (sel == 1) return 35'(longint'($urandom_range(0, 600)) - 300);
      return 35'(longint'($urandom_range(0, 40000)) - 20000);
   endfunction

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_ch     = '0;
      out_ready = 1'b1;
      cfg_we    = 1'b0;
      cfg_ch    = '0;
      cfg_scale = '0;
      cfg_shift = '0;
      sat_clr   = 1'b0;
      n_out     = 0;
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_ch", out_ch, 0);
      check("rst_sat_cnt", sat_cnt, 0);
      check("rst_in_ready", in_ready, 1);

      // identity config saturates a large word
      send_one(1000, 0, 127, "default_sat");
      check("sat_cnt_one", sat_cnt, 1);

      // write ch0 in the same cycle its word is accepted
      cfg_we = 1'b1; cfg_ch = 2'd0; cfg_scale = 16'd1; cfg_shift = 5'd1;
      send_one(10, 0, 10, "collide_old");
      send_one(10, 0, 5, "collide_new");

      // rounding cases
      cfg_we = 1'b1; cfg_ch = 2'd1; cfg_scale = 16'd3; cfg_shift = 5'd4;
      step();
      cfg_we = 1'b1; cfg_ch = 2'd2; cfg_scale = 16'd1; cfg_shift = 5'd3;
      step();
      send_one(37, 1, 7, "round_ch1");
      send_one(1000, 2, 125, "round_ch2");
`ifdef REQUANT_OUT_RELU_EN
      send_one(-1000, 2, 0, "neg_ch2");
`else
      send_one(-1000, 2, -125, "neg_ch2");
`endif

      // 8-word stream with a 5-cycle downstream stall in the middle
      n_out = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         push_word(longint'(i * 13) - 40, i % 4);
         if (i == 3) begin
            out_ready = 1'b0;
            repeat (5) step();
            out_ready = 1'b1;
         end
      end
      drain(8);
      check("bp_count", n_out, 8);
      check("bp_queue_empty", q_data.size(), 0);

      // randomized traffic, backpressure, config writes and clears
      for (int c = 0; c < 600; c++) begin
         if (!in_valid && $urandom_range(0, 3) != 0) begin
            in_valid = 1'b1;
            in_ch    = 2'($urandom_range(0, 3));
            in_data  = rand_data();
         end
         out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 15) == 0) begin
            cfg_we    = 1'b1;
            cfg_ch    = 2'($urandom_range(0, 3));
            cfg_scale = 16'($urandom);
            cfg_shift = 5'($urandom_range(0, 31));
         end
         if ($urandom_range(0, 31) == 0) sat_clr = 1'b1;
         step();
      end
      drain(12);
      check("rand_queue_empty", q_data.size(), 0);

      // reset with words in flight
      out_ready = 1'b0;
      push_word(1000, 1);
      push_word(-5, 2);
      push_word(77, 3);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_in_ready", in_ready, 1);
      check("midrst_sat_cnt", sat_cnt, 0);
      model_reset();
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      n_out = 0;
      drain(8);
      check("midrst_ghost_out", n_out, 0);
      send_one(1000, 1, 127, "post_rst_default");

      // counter ceiling
      n = 0;
      out_ready = 1'b1;
      while (n < 65537) begin
         in_valid = 1'b1;
         in_data  = 35'd1000;
         in_ch    = 2'd3;
         step();
         if (acc) n++;
      end
      drain(6);
      check("sat_cnt_ceiling", sat_cnt, 16'hFFFF);

      // clear coinciding with a saturating out-transfer
      in_valid = 1'b1; in_data = 35'd5000; in_ch = 2'd0;
      step();
      n = 0;
      while (!out_valid && n < 20) begin
         step();
         n++;
      end
      sat_clr = 1'b1;
      step();
      check("sat_clr_priority", sat_cnt, 0);
      drain(4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
